// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding,
// flow-control characters and the baud divisor.
package uart_pkg;

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    START_BIT  = 4'd1,
    DATA_BITS  = 4'd2,
    PARITY_BIT = 4'd3,
    STOP_BIT   = 4'd4
  } rx_state_e;

  localparam logic [7:0] XON_CHAR  = 8'h11;
  localparam logic [7:0] XOFF_CHAR = 8'h13;

  function automatic int unsigned baud_div(
    input int unsigned clk_hz,
    input int unsigned baud,
    input int unsigned os
  );
    return clk_hz / (baud * os);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick divider with restart,
// shared by the UART transmitter and receiver.
module uart_baud_tick #(
  parameter int unsigned DIV = 325
) (
  input  logic clk,
  input  logic reset,
  input  logic restart_i,
  output logic tick_o
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (restart_i || cnt_q == LAST) cnt_d = '0;
  end

  assign tick_o = (cnt_q == LAST) && !restart_i;

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_receiver.sv
// 16x oversampled 8-bit UART receive engine with
// parity/framing/overrun reporting and XON/XOFF handling.
module uart_receiver #(
  parameter int unsigned CLOCK_FREQ = 50000000,
  parameter int unsigned BAUD_RATE  = 9600,
  parameter int unsigned OVERSAMPLE = 16,
  parameter bit          PARITY_EN  = 1'b1,
  parameter bit          XONXOFF_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rts,
  output logic       xoff_rcvd,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun_err
);

  import uart_pkg::*;

  localparam int unsigned DIV =
    baud_div(CLOCK_FREQ, BAUD_RATE, OVERSAMPLE);

  rx_state_e  state_q, state_d;
  logic       sync_q, rx_s_q;
  logic [3:0] samp_q, samp_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic       pbad_q, pbad_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       xoff_q, xoff_d;
  logic       rts_q;
  logic       perr_q, perr_d;
  logic       ferr_q, ferr_d;
  logic       oerr_q, oerr_d;
  logic       restart, tick;

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk       (clk),
    .reset     (reset),
    .restart_i (restart),
    .tick_o    (tick)
  );

  always_comb begin
    state_d = state_q;
    samp_d  = samp_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pbad_d  = pbad_q;
    data_d  = data_q;
    valid_d = valid_q;
    xoff_d  = xoff_q;
    perr_d  = 1'b0;
    ferr_d  = 1'b0;
    oerr_d  = 1'b0;
    restart = 1'b0;
    if (valid_q && rx_ready) valid_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          state_d = START_BIT;
          samp_d  = 4'd0;
          pbad_d  = 1'b0;
          restart = 1'b1;
        end
      end
      START_BIT: begin
        if (tick) begin
          samp_d = samp_q + 4'd1;
          if (samp_q == 4'd7) begin
            samp_d  = 4'd0;
            bit_d   = 3'd0;
            state_d = rx_s_q ? IDLE : DATA_BITS;
          end
        end
      end
      DATA_BITS: begin
        if (tick) begin
          samp_d = samp_q + 4'd1;
          if (samp_q == 4'd15) begin
            shift_d = {rx_s_q, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7)
              state_d = PARITY_EN ? PARITY_BIT : STOP_BIT;
          end
        end
      end
      PARITY_BIT: begin
        if (tick) begin
          samp_d = samp_q + 4'd1;
          if (samp_q == 4'd15) begin
            pbad_d  = rx_s_q != ^shift_q;
            state_d = STOP_BIT;
          end
        end
      end
      STOP_BIT: begin
        if (tick) begin
          samp_d = samp_q + 4'd1;
          if (samp_q == 4'd15) begin
            // Re-arm at mid-stop so back-to-back frames are caught
            state_d = IDLE;
            if (!rx_s_q)
              ferr_d = 1'b1;
            else if (pbad_q)
              perr_d = 1'b1;
            else if (XONXOFF_EN && shift_q == XOFF_CHAR)
              xoff_d = 1'b1;
            else if (XONXOFF_EN && shift_q == XON_CHAR)
              xoff_d = 1'b0;
            else if (valid_q && !rx_ready)
              oerr_d = 1'b1;
            else begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= 1'b1;
      rx_s_q  <= 1'b1;
      state_q <= IDLE;
      samp_q  <= 4'd0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      pbad_q  <= 1'b0;
      data_q  <= 8'd0;
      valid_q <= 1'b0;
      xoff_q  <= 1'b0;
      rts_q   <= 1'b1;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      oerr_q  <= 1'b0;
    end else begin
      sync_q  <= rx;
      rx_s_q  <= sync_q;
      state_q <= state_d;
      samp_q  <= samp_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      pbad_q  <= pbad_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      xoff_q  <= xoff_d;
      rts_q   <= ~valid_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      oerr_q  <= oerr_d;
    end
  end

  assign rx_data     = data_q;
  assign rx_valid    = valid_q;
  assign rts         = rts_q;
  assign xoff_rcvd   = xoff_q;
  assign parity_err  = perr_q;
  assign frame_err   = ferr_q;
  assign overrun_err = oerr_q;

endmodule
